// File: rtl/sweep_mon_pkg.sv
// Shared encodings for the sweep monitor: FSM states, step classes and event direction.
package sweep_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRK_UP = 2'b01,
        TRK_DN = 2'b10
    } trk_e;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_INC  = 2'b01,
        STEP_DEC  = 2'b10,
        STEP_JUMP = 2'b11
    } step_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Step is the mod-16 difference between the live count and last cycle's count.
    function automatic step_e classify(input logic [3:0] d);
        case (d)
            4'h0:    return STEP_HOLD;
            4'h1:    return STEP_INC;
            4'hF:    return STEP_DEC;
            default: return STEP_JUMP;
        endcase
    endfunction

endpackage

// File: rtl/sweep_evt_buf.sv
// One-entry completed-sweep event buffer with valid/ready handshake and sticky overflow.
module sweep_evt_buf
    import sweep_mon_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic load,
    input  logic dir,
    input  logic evt_ready,
    output logic evt_valid,
    output logic evt_dir,
    output logic evt_ovf
);

    logic accept;
    assign accept = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            evt_valid <= 1'b0;
            evt_dir   <= DIR_DN;
            evt_ovf   <= 1'b0;
        end else if (clr) begin
            evt_valid <= 1'b0;
            evt_dir   <= DIR_DN;
            evt_ovf   <= 1'b0;
        end else if (load) begin
            // A slot frees up on the accept edge, so a coincident load is not an overflow.
            if (!evt_valid || accept) begin
                evt_valid <= 1'b1;
                evt_dir   <= dir;
            end else begin
                evt_ovf   <= 1'b1;
            end
        end else if (accept) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sweep_monitor.sv
// Watches a 4-bit up/down counter and reports full 0->F and F->0 sweeps as events.
module sweep_monitor
    import sweep_mon_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       cnt,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_dir,
    output logic [CNT_W-1:0] up_sweeps,
    output logic [CNT_W-1:0] down_sweeps,
    output logic [1:0]       trk,
    output logic             step_err,
    output logic             evt_ovf
);

    logic [3:0] cnt_q;
    trk_e       state;
    step_e      cls;
    logic       cmp_up;
    logic       cmp_dn;

    always_comb begin
        cls    = classify(cnt - cnt_q);
        cmp_up = (state == TRK_UP) && (cls == STEP_INC) && (cnt == 4'hF);
        cmp_dn = (state == TRK_DN) && (cls == STEP_DEC) && (cnt == 4'h0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= 4'h0;
        else        cnt_q <= cnt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            step_err <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            step_err <= 1'b0;
        end else begin
            case (state)
                // Jumps are ignored here so upstream wrap artifacts stay silent.
                IDLE: begin
                    if (cnt_q == 4'h0 && cnt == 4'h1)      state <= TRK_UP;
                    else if (cnt_q == 4'hF && cnt == 4'hE) state <= TRK_DN;
                end
                TRK_UP: begin
                    case (cls)
                        STEP_HOLD: ;
                        STEP_INC:  if (cnt == 4'hF) state <= IDLE;
                        default: begin
                            step_err <= 1'b1;
                            state    <= IDLE;
                        end
                    endcase
                end
                TRK_DN: begin
                    case (cls)
                        STEP_HOLD: ;
                        STEP_DEC:  if (cnt == 4'h0) state <= IDLE;
                        default: begin
                            step_err <= 1'b1;
                            state    <= IDLE;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            up_sweeps   <= '0;
            down_sweeps <= '0;
        end else if (clr) begin
            up_sweeps   <= '0;
            down_sweeps <= '0;
        end else begin
            if (cmp_up && up_sweeps != {CNT_W{1'b1}})
                up_sweeps <= up_sweeps + CNT_W'(1);
            if (cmp_dn && down_sweeps != {CNT_W{1'b1}})
                down_sweeps <= down_sweeps + CNT_W'(1);
        end
    end

    assign trk = state;

    sweep_evt_buf u_evt_buf (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       (clr),
        .load      (cmp_up || cmp_dn),
        .dir       (cmp_up ? DIR_UP : DIR_DN),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_dir   (evt_dir),
        .evt_ovf   (evt_ovf)
    );

endmodule

// File: tb/tb_sweep_monitor.sv
// Directed-vector bench for sweep_monitor; each task checks one feature inline.
module tb_sweep_monitor;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] cnt = 4'h0;
    logic       clr = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic       evt_dir;
    logic [7:0] up_sweeps;
    logic [7:0] down_sweeps;
    logic [1:0] trk;
    logic       step_err;
    logic       evt_ovf;

    int n_chk = 0;
    int n_fail = 0;
    int ev_up = 0;
    int ev_dn = 0;
    int base_up;
    int base_dn;

    sweep_monitor #(.CNT_W(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cnt         (cnt),
        .clr         (clr),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_dir     (evt_dir),
        .up_sweeps   (up_sweeps),
        .down_sweeps (down_sweeps),
        .trk         (trk),
        .step_err    (step_err),
        .evt_ovf     (evt_ovf)
    );

    always #5 clk = ~clk;

    // Count accepted events by direction.
    always @(posedge clk) begin
        if (n_rst && evt_valid && evt_ready) begin
            if (evt_dir) ev_up <= ev_up + 1;
            else         ev_dn <= ev_dn + 1;
        end
    end

    task automatic stp(input logic [3:0] v);
        cnt = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        stp(cnt);
        clr = 1'b0;
    endtask

    task automatic sweep_up();
        for (int i = 0; i < 16; i++) stp(4'(i));
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        cnt = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if ({trk, evt_valid, evt_dir, step_err, evt_ovf} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got trk=%b v=%b d=%b err=%b ovf=%b want all 0", trk, evt_valid, evt_dir, step_err, evt_ovf);
        end
        n_chk++; if (up_sweeps !== 8'h00 || down_sweeps !== 8'h00) begin
            n_fail++; $display("FAIL reset_cnts: got up=%h dn=%h want 00/00", up_sweeps, down_sweeps);
        end
        cnt = 4'h0;
        n_rst = 1'b1;
        stp(4'h0);
    endtask

    task automatic test_up_sweep();
        evt_ready = 1'b1;
        do_clr();
        base_up = ev_up;
        stp(4'h0); stp(4'h0); stp(4'h1);
        n_chk++; if (trk !== 2'b01) begin
            n_fail++; $display("FAIL up_trk: got %b want 01", trk);
        end
        for (int i = 2; i < 16; i++) stp(4'(i));
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || up_sweeps !== 8'd1) begin
            n_fail++; $display("FAIL up_done: got v=%b d=%b up=%0d want 1/1/1", evt_valid, evt_dir, up_sweeps);
        end
        stp(4'h0);
        n_chk++; if (evt_valid !== 1'b0 || ev_up - base_up !== 1 || step_err !== 1'b0 || trk !== 2'b00) begin
            n_fail++; $display("FAIL up_after: got v=%b events=%0d err=%b trk=%b want 0/1/0/00", evt_valid, ev_up - base_up, step_err, trk);
        end
    endtask

    task automatic test_down_sweep();
        evt_ready = 1'b1;
        do_clr();
        base_dn = ev_dn;
        stp(4'h0); stp(4'h0); stp(4'hF); stp(4'hE);
        n_chk++; if (trk !== 2'b10) begin
            n_fail++; $display("FAIL dn_trk: got %b want 10", trk);
        end
        for (int i = 13; i >= 0; i--) stp(4'(i));
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b0 || down_sweeps !== 8'd1) begin
            n_fail++; $display("FAIL dn_done: got v=%b d=%b dn=%0d want 1/0/1", evt_valid, evt_dir, down_sweeps);
        end
        stp(4'hF); stp(4'h0);
        n_chk++; if (step_err !== 1'b0 || trk !== 2'b00 || evt_valid !== 1'b0 || ev_dn - base_dn !== 1) begin
            n_fail++; $display("FAIL dn_after: got err=%b trk=%b v=%b events=%0d want 0/00/0/1", step_err, trk, evt_valid, ev_dn - base_dn);
        end
    endtask

    task automatic test_step_err();
        evt_ready = 1'b1;
        do_clr();
        base_up = ev_up;
        for (int i = 0; i < 6; i++) stp(4'(i));
        stp(4'h9);
        n_chk++; if (step_err !== 1'b1 || trk !== 2'b00) begin
            n_fail++; $display("FAIL jump_err: got err=%b trk=%b want 1/00", step_err, trk);
        end
        stp(4'h9);
        n_chk++; if (evt_valid !== 1'b0 || up_sweeps !== 8'd0 || down_sweeps !== 8'd0 || ev_up !== base_up) begin
            n_fail++; $display("FAIL jump_quiet: got v=%b up=%0d dn=%0d events=%0d want 0/0/0/0", evt_valid, up_sweeps, down_sweeps, ev_up - base_up);
        end
    endtask

    task automatic test_overflow();
        do_clr();
        base_up = ev_up;
        evt_ready = 1'b0;
        sweep_up();
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_first: got v=%b d=%b ovf=%b want 1/1/0", evt_valid, evt_dir, evt_ovf);
        end
        sweep_up();
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_ovf !== 1'b1 || up_sweeps !== 8'd2) begin
            n_fail++; $display("FAIL ovf_second: got v=%b d=%b ovf=%b up=%0d want 1/1/1/2", evt_valid, evt_dir, evt_ovf, up_sweeps);
        end
        evt_ready = 1'b1;
        stp(4'hF);
        n_chk++; if (evt_valid !== 1'b0 || ev_up - base_up !== 1 || evt_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drain: got v=%b events=%0d ovf=%b want 0/1/1", evt_valid, ev_up - base_up, evt_ovf);
        end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b1;
        do_clr();
        base_up = ev_up;
        base_dn = ev_dn;
        evt_ready = 1'b0;
        stp(4'h0); stp(4'hF);
        for (int i = 14; i >= 0; i--) stp(4'(i));
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got v=%b d=%b want 1/0", evt_valid, evt_dir);
        end
        for (int i = 0; i < 15; i++) stp(4'(i));
        evt_ready = 1'b1;
        stp(4'hF);
        n_chk++; if (evt_valid !== 1'b1 || evt_dir !== 1'b1 || evt_ovf !== 1'b0 || up_sweeps !== 8'd1 || ev_dn - base_dn !== 1) begin
            n_fail++; $display("FAIL b2b_swap: got v=%b d=%b ovf=%b up=%0d dn_ev=%0d want 1/1/0/1/1", evt_valid, evt_dir, evt_ovf, up_sweeps, ev_dn - base_dn);
        end
        stp(4'hF);
        n_chk++; if (evt_valid !== 1'b0 || ev_up - base_up !== 1) begin
            n_fail++; $display("FAIL b2b_drain: got v=%b up_ev=%0d want 0/1", evt_valid, ev_up - base_up);
        end
    endtask

    task automatic test_clr();
        do_clr();
        evt_ready = 1'b0;
        sweep_up(); sweep_up();
        stp(4'h0); stp(4'h1); stp(4'h5);
        stp(4'h0); stp(4'h1); stp(4'h2);
        n_chk++; if (trk !== 2'b01 || evt_ovf !== 1'b1 || step_err !== 1'b1) begin
            n_fail++; $display("FAIL clr_setup: got trk=%b ovf=%b err=%b want 01/1/1", trk, evt_ovf, step_err);
        end
        clr = 1'b1;
        stp(4'h3);
        clr = 1'b0;
        n_chk++; if ({trk, evt_valid, step_err, evt_ovf} !== 5'b0 || up_sweeps !== 8'd0) begin
            n_fail++; $display("FAIL clr_all: got trk=%b v=%b err=%b ovf=%b up=%0d want all 0", trk, evt_valid, step_err, evt_ovf, up_sweeps);
        end
        stp(4'h4);
        n_chk++; if (trk !== 2'b00) begin
            n_fail++; $display("FAIL clr_idle: got trk=%b want 00", trk);
        end
        evt_ready = 1'b1;
    endtask

    task automatic test_saturate();
        evt_ready = 1'b1;
        do_clr();
        for (int k = 0; k < 255; k++) sweep_up();
        n_chk++; if (up_sweeps !== 8'hFF) begin
            n_fail++; $display("FAIL sat_reach: got %h want ff", up_sweeps);
        end
        sweep_up();
        n_chk++; if (up_sweeps !== 8'hFF || evt_valid !== 1'b1 || evt_dir !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold: got up=%h v=%b d=%b want ff/1/1", up_sweeps, evt_valid, evt_dir);
        end
        stp(4'h0);
    endtask

    task automatic test_reset_mid_sweep();
        evt_ready = 1'b1;
        do_clr();
        for (int i = 0; i < 8; i++) stp(4'(i));
        n_rst = 1'b0;
        #1;
        n_chk++; if ({trk, evt_valid, evt_dir, step_err, evt_ovf} !== 6'b0 || up_sweeps !== 8'd0 || down_sweeps !== 8'd0) begin
            n_fail++; $display("FAIL rst_async: got trk=%b v=%b up=%0d dn=%0d want all 0", trk, evt_valid, up_sweeps, down_sweeps);
        end
        stp(4'h8);
        n_chk++; if (trk !== 2'b00 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold: got trk=%b v=%b want 00/0", trk, evt_valid);
        end
        cnt = 4'h0;
        n_rst = 1'b1;
        base_up = ev_up;
        sweep_up();
        stp(4'h0);
        n_chk++; if (up_sweeps !== 8'd1 || ev_up - base_up !== 1 || step_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_resume: got up=%0d events=%0d err=%b want 1/1/0", up_sweeps, ev_up - base_up, step_err);
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_step_err();
        test_overflow();
        test_back_to_back();
        test_clr();
        test_saturate();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
